// File: rtl/exp_golomb_decode.sv
// Exp-Golomb (order k) bitstream decoder with a 32-bit refillable bit buffer.
// Optional trailing sign bit for AC levels; overflow of the zero prefix reports err.
module exp_golomb_decode (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [2:0]  k,
    input  logic        is_ac_level,
    input  logic [31:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        flush,
    output logic [31:0] val,
    output logic        minus,
    output logic [31:0] codeword_length,
    output logic        err,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy
);

    // state | meaning
    // IDLE  | waiting for start
    // ZEROS | counting the leading-zero prefix
    // BITS  | shifting the remaining suffix bits into acc
    // SIGN  | reading the trailing sign bit (AC levels only)
    // DONE  | result valid, held until out_ready
    // ERR   | zero prefix overflowed, held until out_ready
    typedef enum logic [2:0] {
        S_IDLE, S_ZEROS, S_BITS, S_SIGN, S_DONE, S_ERR
    } state_t;

    state_t      state;
    logic [31:0] sh_buf;
    logic [5:0]  bits_left;
    logic [2:0]  k_r;
    logic        ac_r;
    logic [5:0]  zcnt;
    logic [5:0]  rem;
    logic [31:0] acc;

    logic        bit_avail;
    logic        cur_bit;
    logic        consume;
    logic [5:0]  zcnt_inc;
    logic [5:0]  zlimit;
    logic [5:0]  rem_init;
    logic [31:0] acc_shift;
    logic [31:0] k_pow;
    logic [31:0] len_done;

    assign in_ready  = (bits_left == 6'd0);
    assign busy      = (state != S_IDLE);
    assign bit_avail = (bits_left != 6'd0);
    assign cur_bit   = sh_buf[31];
    assign consume   = bit_avail &&
                       (state == S_ZEROS || state == S_BITS || state == S_SIGN);
    assign zcnt_inc  = zcnt + 6'd1;
    assign zlimit    = 6'd32 - {3'd0, k_r};
    assign rem_init  = zcnt + {3'd0, k_r};
    assign acc_shift = (acc << 1) | {31'd0, cur_bit};
    assign k_pow     = 32'd1 << k_r;
    assign len_done  = {25'd0, zcnt, 1'b0} + {29'd0, k_r} + 32'd1 + {31'd0, ac_r};

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state           <= S_IDLE;
            sh_buf          <= 32'd0;
            bits_left       <= 6'd0;
            k_r             <= 3'd0;
            ac_r            <= 1'b0;
            zcnt            <= 6'd0;
            rem             <= 6'd0;
            acc             <= 32'd0;
            val             <= 32'd0;
            minus           <= 1'b0;
            codeword_length <= 32'd0;
            err             <= 1'b0;
            out_valid       <= 1'b0;
        end else if (flush) begin
            bits_left <= 6'd0;
            state     <= S_IDLE;
            out_valid <= 1'b0;
        end else begin
            // a load and a consume can never coincide: loads need an empty buffer
            if (in_valid && in_ready) begin
                sh_buf    <= in_data;
                bits_left <= 6'd32;
            end else if (consume) begin
                sh_buf    <= sh_buf << 1;
                bits_left <= bits_left - 6'd1;
            end

            case (state)
                S_IDLE: begin
                    if (start) begin
                        k_r   <= k;
                        ac_r  <= is_ac_level;
                        zcnt  <= 6'd0;
                        acc   <= 32'd0;
                        state <= S_ZEROS;
                    end
                end
                S_ZEROS: begin
                    if (bit_avail) begin
                        if (!cur_bit) begin
                            zcnt <= zcnt_inc;
                            if (zcnt_inc == zlimit) begin
                                state           <= S_ERR;
                                val             <= 32'd0;
                                minus           <= 1'b0;
                                err             <= 1'b1;
                                codeword_length <= {26'd0, zcnt_inc};
                                out_valid       <= 1'b1;
                            end
                        end else begin
                            acc <= 32'd1;
                            rem <= rem_init;
                            if (rem_init != 6'd0) begin
                                state <= S_BITS;
                            end else if (ac_r) begin
                                state <= S_SIGN;
                            end else begin
                                // only reachable with k=0, zcnt=0: value 0
                                state           <= S_DONE;
                                val             <= 32'd1 - k_pow;
                                minus           <= 1'b0;
                                err             <= 1'b0;
                                codeword_length <= len_done;
                                out_valid       <= 1'b1;
                            end
                        end
                    end
                end
                S_BITS: begin
                    if (bit_avail) begin
                        acc <= acc_shift;
                        rem <= rem - 6'd1;
                        if (rem == 6'd1) begin
                            if (ac_r) begin
                                state <= S_SIGN;
                            end else begin
                                state           <= S_DONE;
                                val             <= acc_shift - k_pow;
                                minus           <= 1'b0;
                                err             <= 1'b0;
                                codeword_length <= len_done;
                                out_valid       <= 1'b1;
                            end
                        end
                    end
                end
                S_SIGN: begin
                    if (bit_avail) begin
                        state           <= S_DONE;
                        val             <= acc - k_pow;
                        minus           <= cur_bit;
                        err             <= 1'b0;
                        codeword_length <= len_done;
                        out_valid       <= 1'b1;
                    end
                end
                S_DONE, S_ERR: begin
                    if (out_ready) begin
                        state     <= S_IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_exp_golomb_decode.sv
// Bench for exp_golomb_decode: directed corner cases plus a random stream
// encoded from the code definition and compared per codeword.
module tb_exp_golomb_decode;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [2:0]  k;
    logic        is_ac_level;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic        flush;
    logic [31:0] val;
    logic        minus;
    logic [31:0] codeword_length;
    logic        err;
    logic        out_valid;
    logic        out_ready;
    logic        busy;

    always #5 clk = ~clk;

    exp_golomb_decode dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .start           (start),
        .k               (k),
        .is_ac_level     (is_ac_level),
        .in_data         (in_data),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .flush           (flush),
        .val             (val),
        .minus           (minus),
        .codeword_length (codeword_length),
        .err             (err),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .busy            (busy)
    );

    typedef struct {
        logic [2:0]  k;
        bit          ac;
        logic [31:0] v;
        bit          m;
        int          len;
        bit          e;
    } cw_t;

    int          n_chk = 0;
    int          n_pass = 0;
    logic [31:0] words[$];
    int          widx = 0;
    bit          feed_en = 0;
    logic        rdy_s = 1'b0;
    bit          bq[$];
    cw_t         cws[$];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    endtask

    // one clock; the feeder offers the next word whenever words remain
    task automatic tick();
        @(negedge clk);
        if (in_valid && rdy_s) widx++;
        rdy_s    = in_ready;
        in_valid = feed_en && (widx < words.size());
        in_data  = in_valid ? words[widx] : 32'd0;
    endtask

    task automatic flush_stream();
        feed_en  = 0;
        in_valid = 1'b0;
        flush    = 1'b1;
        tick();
        flush = 1'b0;
        words.delete();
        widx = 0;
    endtask

    task automatic wait_loaded();
        int cnt;
        feed_en = 1;
        cnt = 0;
        do begin
            tick();
            cnt++;
        end while (in_ready && cnt < 20);
        chk("load", 32'(in_ready), 32'd0);
    endtask

    task automatic decode(input logic [2:0] kk, input bit ac, output int lat, output bit saw);
        k           = kk;
        is_ac_level = ac;
        start       = 1'b1;
        tick();
        start = 1'b0;
        lat   = 0;
        saw   = 0;
        while (!out_valid && lat < 300) begin
            tick();
            lat++;
            if (in_ready) saw = 1;
        end
        chk("out_valid", 32'(out_valid), 32'd1);
    endtask

    task automatic check_res(input string t, input logic [31:0] v, input bit m,
                             input int len, input bit e);
        chk({t, ".val"}, val, v);
        chk({t, ".minus"}, 32'(minus), 32'(m));
        chk({t, ".len"}, codeword_length, 32'(len));
        chk({t, ".err"}, 32'(err), 32'(e));
    endtask

    task automatic accept();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("idle_after_accept", 32'(busy), 32'd0);
    endtask

    // encoder straight from the code definition: q zeros, sum in binary, optional sign
    task automatic encode(input logic [2:0] kk, input bit ac);
        int          q, nb;
        logic [63:0] low, sum;
        cw_t         c;
        q   = $urandom_range(0, 31 - int'(kk));
        nb  = q + int'(kk);
        low = {$urandom, $urandom};
        sum = (64'd1 << nb) | (low & ((64'd1 << nb) - 64'd1));
        c.k   = kk;
        c.ac  = ac;
        c.v   = 32'(sum - (64'd1 << kk));
        c.m   = ac ? 1'($urandom_range(0, 1)) : 1'b0;
        c.len = 2 * q + int'(kk) + 1 + int'(ac);
        c.e   = 0;
        for (int i = 0; i < q; i++) bq.push_back(1'b0);
        for (int i = nb; i >= 0; i--) bq.push_back(sum[i]);
        if (ac) bq.push_back(c.m);
        cws.push_back(c);
    endtask

    int          lat;
    bit          saw;
    logic [31:0] word;
    logic [2:0]  rk;
    cw_t         c;

    initial begin
        reset_n     = 1'b0;
        start       = 1'b0;
        k           = 3'd0;
        is_ac_level = 1'b0;
        in_data     = 32'd0;
        in_valid    = 1'b0;
        flush       = 1'b0;
        out_ready   = 1'b0;

        // reset state
        tick();
        tick();
        check_res("reset", 32'd0, 0, 0, 0);
        chk("reset.out_valid", 32'(out_valid), 32'd0);
        chk("reset.busy", 32'(busy), 32'd0);
        reset_n = 1'b1;
        tick();
        chk("reset.in_ready", 32'(in_ready), 32'd1);

        // single '1' bit, k=0
        words.push_back(32'h8000_0000);
        wait_loaded();
        decode(3'd0, 0, lat, saw);
        check_res("one_bit", 32'd0, 0, 1, 0);
        chk("one_bit.lat", 32'(lat), 32'd1);
        accept();

        // 00100 then k=2 AC 010011
        flush_stream();
        words.push_back(32'h227F_FFFF);
        wait_loaded();
        decode(3'd0, 0, lat, saw);
        check_res("cw00100", 32'd3, 0, 5, 0);
        chk("cw00100.lat", 32'(lat), 32'd5);
        accept();
        decode(3'd2, 1, lat, saw);
        check_res("ac_k2", 32'd5, 1, 6, 0);
        chk("ac_k2.lat", 32'(lat), 32'd6);
        accept();

        // 29-bit codeword, then 00100 straddling the word boundary
        flush_stream();
        words.push_back(32'h0002_0001);
        words.push_back(32'h3FFF_FFFF);
        wait_loaded();
        decode(3'd0, 0, lat, saw);
        check_res("long29", 32'd16383, 0, 29, 0);
        chk("long29.lat", 32'(lat), 32'd29);
        accept();
        decode(3'd0, 0, lat, saw);
        check_res("split", 32'd3, 0, 5, 0);
        chk("split.lat", 32'(lat), 32'd6);
        chk("split.in_ready_pulse", 32'(saw), 32'd1);
        accept();

        // prefix overflow
        flush_stream();
        words.push_back(32'h0000_0000);
        words.push_back(32'hFFFF_FFFF);
        wait_loaded();
        decode(3'd0, 0, lat, saw);
        check_res("overflow", 32'd0, 0, 32, 1);
        chk("overflow.lat", 32'(lat), 32'd32);
        accept();

        // hold in DONE with start asserted; start in the accept cycle is ignored
        flush_stream();
        words.push_back(32'h227F_FFFF);
        wait_loaded();
        decode(3'd0, 0, lat, saw);
        start = 1'b1;
        k     = 3'd5;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold.out_valid", 32'(out_valid), 32'd1);
            chk("hold.val", val, 32'd3);
        end
        chk("hold.len", codeword_length, 32'd5);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        start     = 1'b0;
        chk("hold.start_ignored", 32'(busy), 32'd0);
        decode(3'd2, 1, lat, saw);
        check_res("after_hold", 32'd5, 1, 6, 0);
        accept();

        // flush mid-decode keeps the last results
        flush_stream();
        words.push_back(32'h0000_0000);
        wait_loaded();
        k     = 3'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        feed_en  = 0;
        in_valid = 1'b0;
        flush    = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush.busy", 32'(busy), 32'd0);
        chk("flush.out_valid", 32'(out_valid), 32'd0);
        chk("flush.in_ready", 32'(in_ready), 32'd1);
        check_res("flush", 32'd5, 1, 6, 0);

        // reset during BITS
        words.delete();
        widx = 0;
        words.push_back(32'h8000_0000);
        wait_loaded();
        k     = 3'd7;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("bits.busy", 32'(busy), 32'd1);
        feed_en  = 0;
        in_valid = 1'b0;
        reset_n  = 1'b0;
        tick();
        check_res("mid_reset", 32'd0, 0, 0, 0);
        chk("mid_reset.busy", 32'(busy), 32'd0);
        chk("mid_reset.in_ready", 32'(in_ready), 32'd1);
        reset_n = 1'b1;
        saw     = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (out_valid) saw = 1;
        end
        chk("mid_reset.no_out_valid", 32'(saw), 32'd0);

        // random stream, ending in an overflow codeword
        flush_stream();
        bq.delete();
        cws.delete();
        for (int i = 0; i < 30; i++) begin
            rk = 3'($urandom_range(0, 7));
            encode(rk, 1'($urandom_range(0, 1)));
        end
        rk    = 3'($urandom_range(0, 7));
        c.k   = rk;
        c.ac  = 1'($urandom_range(0, 1));
        c.v   = 32'd0;
        c.m   = 0;
        c.len = 32 - int'(rk);
        c.e   = 1;
        for (int i = 0; i < c.len; i++) bq.push_back(1'b0);
        cws.push_back(c);
        while (bq.size() % 32 != 0) bq.push_back(1'b1);
        for (int w = 0; w < bq.size() / 32; w++) begin
            word = 32'd0;
            for (int b = 0; b < 32; b++) word = {word[30:0], bq[w * 32 + b]};
            words.push_back(word);
        end
        wait_loaded();
        foreach (cws[i]) begin
            decode(cws[i].k, cws[i].ac, lat, saw);
            repeat ($urandom_range(0, 3)) tick();
            check_res($sformatf("rnd%0d", i), cws[i].v, cws[i].m, cws[i].len, cws[i].e);
            chk($sformatf("rnd%0d.lat_lo", i), 32'(lat >= cws[i].len), 32'd1);
            chk($sformatf("rnd%0d.lat_hi", i), 32'(lat <= cws[i].len + 2), 32'd1);
            accept();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
